// File: rtl/z8_sequencer.sv
// z8 core control unit: fetches opcode/operand pairs over a req/ack memory
// port and sequences execute, memory access and writeback; owns PC and SP.
module z8_sequencer #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] SP_INIT  = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  input  logic [7:0]        acc_i,
  input  logic [7:0]        reg_rdata,
  input  logic              flag_z,
  input  logic              flag_n,
  output logic [7:0]        opcode_o,
  output logic [7:0]        operand_o,
  output logic [2:0]        reg_idx,
  output logic              exec_stb,
  output logic              wb_stb,
  output logic              wb_sel,
  output logic [7:0]        mem_data_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] sp_o,
  output logic              trap
);

  localparam logic [2:0] S_FETCH_OP  = 3'd0;
  localparam logic [2:0] S_FETCH_ARG = 3'd1;
  localparam logic [2:0] S_EXEC      = 3'd2;
  localparam logic [2:0] S_MEM       = 3'd3;
  localparam logic [2:0] S_WB        = 3'd4;
  localparam logic [2:0] S_TRAP      = 3'd5;

  localparam logic [7:0] OP_NOP   = 8'd0;
  localparam logic [7:0] OP_LDD   = 8'd1;
  localparam logic [7:0] OP_LDD_I = 8'd2;
  localparam logic [7:0] OP_LDR   = 8'd3;
  localparam logic [7:0] OP_STR   = 8'd4;
  localparam logic [7:0] OP_STR_I = 8'd5;
  localparam logic [7:0] OP_ADC   = 8'd6;
  localparam logic [7:0] OP_SRA   = 8'd17;
  localparam logic [7:0] OP_PSH   = 8'd18;
  localparam logic [7:0] OP_POP   = 8'd19;
  localparam logic [7:0] OP_JMP   = 8'd20;
  localparam logic [7:0] OP_JZ    = 8'd23;
  localparam logic [7:0] OP_JNZ   = 8'd24;
  localparam logic [7:0] OP_JN    = 8'd25;
  localparam logic [7:0] OP_SB    = 8'd26;
  localparam logic [7:0] OP_CB    = 8'd27;
  localparam logic [7:0] OP_LIMIT = 8'd28;

  logic [2:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] sp;
  logic              take_jump;
  logic              no_exec;
  logic              is_mem_op;
  logic              is_wb_op;
  logic              is_load;

  always_comb begin
    take_jump = 1'b0;
    case (opcode_o)
      OP_JMP:  take_jump = 1'b1;
      OP_JZ:   take_jump = flag_z;
      OP_JNZ:  take_jump = !flag_z;
      OP_JN:   take_jump = flag_n;
      default: take_jump = 1'b0;
    endcase
  end

  assign no_exec   = opcode_o inside {OP_NOP, OP_JMP, OP_JZ, OP_JNZ, OP_JN};
  assign is_mem_op = opcode_o inside {OP_LDR, OP_STR, OP_STR_I, OP_PSH, OP_POP};
  assign is_wb_op  = (opcode_o inside {OP_LDD, OP_LDD_I, OP_SB, OP_CB}) ||
                     (opcode_o >= OP_ADC && opcode_o <= OP_SRA);
  assign is_load   = (opcode_o == OP_LDR) || (opcode_o == OP_POP);

  // Every memory state spends one idle cycle issuing the request, so mem_req
  // is always low in the cycle after an ack and after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH_OP;
      pc         <= RESET_PC;
      sp         <= SP_INIT;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      opcode_o   <= '0;
      operand_o  <= '0;
      mem_data_o <= '0;
    end else begin
      case (state)
        S_FETCH_OP: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end else if (mem_ack) begin
            mem_req  <= 1'b0;
            opcode_o <= mem_rdata;
            state    <= (mem_rdata >= OP_LIMIT) ? S_TRAP : S_FETCH_ARG;
          end
        end
        S_FETCH_ARG: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc + ADDR_W'(1);
          end else if (mem_ack) begin
            mem_req   <= 1'b0;
            operand_o <= mem_rdata;
            state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          pc <= take_jump ? ADDR_W'(operand_o) : pc + ADDR_W'(2);
          if (is_mem_op)     state <= S_MEM;
          else if (is_wb_op) state <= S_WB;
          else               state <= S_FETCH_OP;
        end
        S_MEM: begin
          // Address and data are captured once at issue and held until the ack.
          if (!mem_req) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= ADDR_W'(reg_rdata);
            mem_wdata <= acc_i;
            case (opcode_o)
              OP_STR:   mem_we <= 1'b1;
              OP_STR_I: begin
                mem_we   <= 1'b1;
                mem_addr <= ADDR_W'(operand_o);
              end
              OP_PSH: begin
                mem_we    <= 1'b1;
                mem_addr  <= sp;
                mem_wdata <= reg_rdata;
              end
              OP_POP: begin
                mem_addr <= sp + ADDR_W'(1);
                sp       <= sp + ADDR_W'(1);
              end
              default: ;
            endcase
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!mem_we) mem_data_o <= mem_rdata;
            if (opcode_o == OP_PSH) sp <= sp - ADDR_W'(1);
            state <= is_load ? S_WB : S_FETCH_OP;
          end
        end
        S_WB:    state <= S_FETCH_OP;
        S_TRAP:  state <= S_TRAP;
        default: state <= S_TRAP;
      endcase
    end
  end

  assign exec_stb = (state == S_EXEC) && !no_exec;
  assign wb_stb   = (state == S_WB);
  assign wb_sel   = (state == S_WB) && is_load;
  assign trap     = (state == S_TRAP);
  assign reg_idx  = operand_o[2:0];
  assign pc_o     = pc;
  assign sp_o     = sp;

endmodule

// File: tb/tb_z8_sequencer.sv
// Directed bench for z8_sequencer: a req/ack memory model with programmable
// ack latency, a table of single-instruction vectors and multi-cycle sequences.
module tb_z8_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic [7:0] acc_i;
  logic [7:0] reg_rdata;
  logic       flag_z;
  logic       flag_n;
  logic [7:0] opcode_o;
  logic [7:0] operand_o;
  logic [2:0] reg_idx;
  logic       exec_stb;
  logic       wb_stb;
  logic       wb_sel;
  logic [7:0] mem_data_o;
  logic [7:0] pc_o;
  logic [7:0] sp_o;
  logic       trap;

  z8_sequencer dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .acc_i(acc_i), .reg_rdata(reg_rdata), .flag_z(flag_z), .flag_n(flag_n),
    .opcode_o(opcode_o), .operand_o(operand_o), .reg_idx(reg_idx),
    .exec_stb(exec_stb), .wb_stb(wb_stb), .wb_sel(wb_sel),
    .mem_data_o(mem_data_o), .pc_o(pc_o), .sp_o(sp_o), .trap(trap)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic [7:0] regs [8];
  logic [7:0] reqAddrLog [4096];
  int         reqLenLog [4096];

  int         ackDelay = 1;
  int         reqCnt = 0;
  int         execCnt = 0;
  int         wbCnt = 0;
  int         wrCnt = 0;
  int         stableErr = 0;
  int         trapReqErr = 0;
  logic       lastWbSel = 1'b0;
  logic [7:0] lastWrAddr = '0;
  logic [7:0] lastWrData = '0;

  int total = 0;
  int bad = 0;

  always_comb reg_rdata = regs[reg_idx];

  // Memory responder and event monitor; everything is sampled on the falling
  // edge so the DUT outputs have settled after the rising edge.
  initial begin
    int   holdCnt;
    logic prevReq;
    logic [7:0] curAddr;
    logic [7:0] curData;
    logic curWe;
    holdCnt = 0; prevReq = 1'b0; curAddr = '0; curData = '0; curWe = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (!prevReq) begin
          if (reqCnt < 4096) reqAddrLog[reqCnt] = mem_addr;
          reqCnt++;
          curAddr = mem_addr; curWe = mem_we; curData = mem_wdata;
          holdCnt = 0;
        end else if (mem_addr !== curAddr || mem_we !== curWe ||
                     (curWe && mem_wdata !== curData)) begin
          stableErr++;
        end
        holdCnt++;
        if (holdCnt == ackDelay + 1) begin
          mem_ack = 1'b1;
          if (reqCnt <= 4096) reqLenLog[reqCnt-1] = holdCnt;
          if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            wrCnt++;
            lastWrAddr = mem_addr;
            lastWrData = mem_wdata;
          end else begin
            mem_rdata = mem[mem_addr];
          end
        end else begin
          mem_ack = 1'b0;
        end
      end else begin
        mem_ack = 1'b0;
        holdCnt = 0;
      end
      prevReq = mem_req;
      if (exec_stb) execCnt++;
      if (wb_stb) begin
        wbCnt++;
        lastWbSel = wb_sel;
      end
      if (trap && mem_req) trapReqErr++;
    end
  end

  typedef struct {
    logic [7:0] op;
    logic [7:0] arg;
    logic       z;
    logic       n;
    logic [7:0] acc;
    logic [7:0] expPc;
    int         expExec;
    int         expWb;
    logic       expWbSel;
    int         expReqs;
    logic [7:0] expMemData;
    int         expWr;
    logic [7:0] wrAddr;
    logic [7:0] wrData;
  } vec_t;

  vec_t vecs [15];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic clearMem();
    for (int k = 0; k < 256; k++) mem[k] = 8'h00;
  endtask

  task automatic waitReqs(input int base, input int n, input int budget, input string name);
    int cycles;
    cycles = 0;
    while ((reqCnt - base) < n && cycles < budget) begin
      @(negedge clk);
      #1;
      cycles++;
    end
    checkOutput({name, "_reqs_reached"}, 32'((reqCnt - base) >= n), 32'd1);
  endtask

  task automatic applyStimulus(input int i);
    vec_t v;
    int   baseReq, baseExec, baseWb, baseWr;
    v = vecs[i];
    clearMem();
    mem[8'h00] = v.op;
    mem[8'h01] = v.arg;
    mem[8'h12] = 8'hA7;
    flag_z = v.z;
    flag_n = v.n;
    acc_i = v.acc;
    ackDelay = 1;
    doReset();
    baseReq = reqCnt; baseExec = execCnt; baseWb = wbCnt; baseWr = wrCnt;
    waitReqs(baseReq, v.expReqs + 1, 60, $sformatf("v%0d", i));
    checkOutput($sformatf("v%0d_pc", i), 32'(pc_o), 32'(v.expPc));
    checkOutput($sformatf("v%0d_next_fetch", i), 32'(reqAddrLog[baseReq + v.expReqs]), 32'(v.expPc));
    checkOutput($sformatf("v%0d_exec_cnt", i), 32'(execCnt - baseExec), 32'(v.expExec));
    checkOutput($sformatf("v%0d_wb_cnt", i), 32'(wbCnt - baseWb), 32'(v.expWb));
    checkOutput($sformatf("v%0d_mem_data", i), 32'(mem_data_o), 32'(v.expMemData));
    checkOutput($sformatf("v%0d_wr_cnt", i), 32'(wrCnt - baseWr), 32'(v.expWr));
    checkOutput($sformatf("v%0d_fetch_len", i), 32'(reqLenLog[baseReq]), 32'd2);
    if (v.expWb > 0)
      checkOutput($sformatf("v%0d_wb_sel", i), 32'(lastWbSel), 32'(v.expWbSel));
    if (v.expWr > 0) begin
      checkOutput($sformatf("v%0d_wr_addr", i), 32'(lastWrAddr), 32'(v.wrAddr));
      checkOutput($sformatf("v%0d_wr_data", i), 32'(lastWrData), 32'(v.wrData));
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int baseReq, baseExec, baseWb, baseWr, baseTrapErr, baseStable;

    //         op     arg    z     n     acc    pc     ex wb sel   rq md     wr addr   data
    vecs[0]  = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h02, 0, 0, 1'b0, 2, 8'h00, 0, 8'h00, 8'h00};
    vecs[1]  = '{8'h17, 8'h40, 1'b1, 1'b0, 8'h00, 8'h40, 0, 0, 1'b0, 2, 8'h00, 0, 8'h00, 8'h00};
    vecs[2]  = '{8'h17, 8'h40, 1'b0, 1'b0, 8'h00, 8'h02, 0, 0, 1'b0, 2, 8'h00, 0, 8'h00, 8'h00};
    vecs[3]  = '{8'h18, 8'h40, 1'b0, 1'b0, 8'h00, 8'h40, 0, 0, 1'b0, 2, 8'h00, 0, 8'h00, 8'h00};
    vecs[4]  = '{8'h18, 8'h40, 1'b1, 1'b0, 8'h00, 8'h02, 0, 0, 1'b0, 2, 8'h00, 0, 8'h00, 8'h00};
    vecs[5]  = '{8'h19, 8'h33, 1'b0, 1'b1, 8'h00, 8'h33, 0, 0, 1'b0, 2, 8'h00, 0, 8'h00, 8'h00};
    vecs[6]  = '{8'h19, 8'h33, 1'b0, 1'b0, 8'h00, 8'h02, 0, 0, 1'b0, 2, 8'h00, 0, 8'h00, 8'h00};
    vecs[7]  = '{8'h14, 8'h80, 1'b1, 1'b1, 8'h00, 8'h80, 0, 0, 1'b0, 2, 8'h00, 0, 8'h00, 8'h00};
    vecs[8]  = '{8'h07, 8'h07, 1'b0, 1'b0, 8'h00, 8'h02, 1, 1, 1'b0, 2, 8'h00, 0, 8'h00, 8'h00};
    vecs[9]  = '{8'h15, 8'h05, 1'b1, 1'b0, 8'h00, 8'h02, 1, 0, 1'b0, 2, 8'h00, 0, 8'h00, 8'h00};
    vecs[10] = '{8'h1B, 8'h00, 1'b0, 1'b0, 8'h00, 8'h02, 1, 1, 1'b0, 2, 8'h00, 0, 8'h00, 8'h00};
    vecs[11] = '{8'h03, 8'h02, 1'b0, 1'b0, 8'h00, 8'h02, 1, 1, 1'b1, 3, 8'hA7, 0, 8'h00, 8'h00};
    vecs[12] = '{8'h05, 8'h50, 1'b0, 1'b0, 8'h3C, 8'h02, 1, 0, 1'b0, 3, 8'h00, 1, 8'h50, 8'h3C};
    vecs[13] = '{8'h04, 8'h02, 1'b0, 1'b0, 8'hC3, 8'h02, 1, 0, 1'b0, 3, 8'h00, 1, 8'h12, 8'hC3};
    vecs[14] = '{8'h0E, 8'h01, 1'b0, 1'b0, 8'h00, 8'h02, 1, 1, 1'b0, 2, 8'h00, 0, 8'h00, 8'h00};

    for (int r = 0; r < 8; r++) regs[r] = 8'h10 + 8'(r);
    regs[3] = 8'h5A;
    rst = 1'b1;
    flag_z = 1'b0;
    flag_n = 1'b0;
    acc_i = 8'h00;
    clearMem();

    $display("[TB] reset state");
    doReset();
    checkOutput("rst_pc", 32'(pc_o), 32'h00);
    checkOutput("rst_sp", 32'(sp_o), 32'hFF);
    checkOutput("rst_req", 32'(mem_req), 32'd0);
    checkOutput("rst_we", 32'(mem_we), 32'd0);
    checkOutput("rst_trap", 32'(trap), 32'd0);
    checkOutput("rst_strobes", 32'({exec_stb, wb_stb, wb_sel}), 32'd0);
    checkOutput("rst_latches", 32'({opcode_o, operand_o, mem_data_o}), 32'd0);

    $display("[TB] single-instruction vectors");
    for (int i = 0; i < 15; i++) applyStimulus(i);

    // PSH r3 then POP r1 through the stack top at FF.
    $display("[TB] push/pop sequence");
    clearMem();
    mem[8'h00] = 8'h12; mem[8'h01] = 8'h03;
    mem[8'h02] = 8'h13; mem[8'h03] = 8'h01;
    ackDelay = 1;
    doReset();
    baseReq = reqCnt; baseWb = wbCnt; baseWr = wrCnt;
    waitReqs(baseReq, 4, 60, "psh");
    checkOutput("psh_wr_cnt", 32'(wrCnt - baseWr), 32'd1);
    checkOutput("psh_wr_addr", 32'(lastWrAddr), 32'hFF);
    checkOutput("psh_wr_data", 32'(lastWrData), 32'h5A);
    checkOutput("psh_sp", 32'(sp_o), 32'hFE);
    checkOutput("psh_no_wb", 32'(wbCnt - baseWb), 32'd0);
    waitReqs(baseReq, 7, 60, "pop");
    checkOutput("pop_rd_addr", 32'(reqAddrLog[baseReq + 5]), 32'hFF);
    checkOutput("pop_mem_data", 32'(mem_data_o), 32'h5A);
    checkOutput("pop_wb_cnt", 32'(wbCnt - baseWb), 32'd1);
    checkOutput("pop_wb_sel", 32'(lastWbSel), 32'd1);
    checkOutput("pop_sp", 32'(sp_o), 32'hFF);
    checkOutput("pop_next_fetch", 32'(reqAddrLog[baseReq + 6]), 32'h04);

    $display("[TB] illegal opcode");
    clearMem();
    mem[8'h00] = 8'h1C;
    doReset();
    baseReq = reqCnt; baseExec = execCnt; baseTrapErr = trapReqErr;
    repeat (12) @(negedge clk);
    #1;
    checkOutput("trap_set", 32'(trap), 32'd1);
    checkOutput("trap_req", 32'(mem_req), 32'd0);
    checkOutput("trap_req_cnt", 32'(reqCnt - baseReq), 32'd1);
    checkOutput("trap_req_seen", 32'(trapReqErr - baseTrapErr), 32'd0);
    checkOutput("trap_no_exec", 32'(execCnt - baseExec), 32'd0);
    checkOutput("trap_pc", 32'(pc_o), 32'h00);
    doReset();
    checkOutput("trap_cleared", 32'(trap), 32'd0);
    checkOutput("trap_rst_pc", 32'(pc_o), 32'h00);

    // Jump to FF, then ADC_I there with a slow memory: operand wraps to 00.
    $display("[TB] pc wrap with slow ack");
    clearMem();
    mem[8'h00] = 8'h14; mem[8'h01] = 8'hFF;
    mem[8'hFF] = 8'h07;
    ackDelay = 5;
    doReset();
    baseReq = reqCnt; baseExec = execCnt; baseStable = stableErr;
    waitReqs(baseReq, 5, 200, "wrap");
    checkOutput("wrap_op_addr", 32'(reqAddrLog[baseReq + 2]), 32'hFF);
    checkOutput("wrap_arg_addr", 32'(reqAddrLog[baseReq + 3]), 32'h00);
    checkOutput("wrap_next_fetch", 32'(reqAddrLog[baseReq + 4]), 32'h01);
    checkOutput("wrap_pc", 32'(pc_o), 32'h01);
    checkOutput("wrap_operand", 32'(operand_o), 32'h14);
    checkOutput("wrap_exec_cnt", 32'(execCnt - baseExec), 32'd1);
    checkOutput("wrap_req_len", 32'(reqLenLog[baseReq + 3]), 32'd6);
    checkOutput("wrap_addr_stable", 32'(stableErr - baseStable), 32'd0);

    // Reset lands while POP's read is outstanding.
    $display("[TB] reset during memory access");
    clearMem();
    mem[8'h00] = 8'h13; mem[8'h01] = 8'h00;
    ackDelay = 20;
    doReset();
    baseReq = reqCnt;
    waitReqs(baseReq, 3, 200, "midrst");
    checkOutput("midrst_pop_sp", 32'(sp_o), 32'h00);
    checkOutput("midrst_req_up", 32'(mem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("midrst_req_drop", 32'(mem_req), 32'd0);
    checkOutput("midrst_sp", 32'(sp_o), 32'hFF);
    checkOutput("midrst_pc", 32'(pc_o), 32'h00);
    rst = 1'b0;
    ackDelay = 1;
    baseReq = reqCnt;
    waitReqs(baseReq, 1, 20, "midrst_restart");
    checkOutput("midrst_fetch_addr", 32'(reqAddrLog[baseReq]), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
